// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - four-way VRAM port arbiter with CPU aging and read timeout
// One transaction in flight; fixed priority scr > spr > cpu > cmd, aged CPU jumps ahead of spr/cmd.
module vdp_vram_arbiter #(
    parameter int CPU_AGE_LIMIT = 16,
    parameter int READ_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        initial_busy,
    input  logic [16:0] scr_address,
    input  logic [16:0] spr_address,
    input  logic [16:0] cpu_address,
    input  logic [16:0] cmd_address,
    input  logic        scr_valid,
    input  logic        spr_valid,
    input  logic        cpu_valid,
    input  logic        cmd_valid,
    input  logic        cpu_write,
    input  logic        cmd_write,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  cmd_wdata,
    output logic        scr_ready,
    output logic        spr_ready,
    output logic        cpu_ready,
    output logic        cmd_ready,
    output logic [31:0] scr_rdata,
    output logic [31:0] spr_rdata,
    output logic [31:0] cpu_rdata,
    output logic [31:0] cmd_rdata,
    output logic        scr_rdata_en,
    output logic        spr_rdata_en,
    output logic        cpu_rdata_en,
    output logic        cmd_rdata_en,
    output logic [16:0] vram_address,
    output logic        vram_write,
    output logic        vram_valid,
    output logic [7:0]  vram_wdata,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en,
    output logic        timeout_error
);
    localparam int AW = $clog2(CPU_AGE_LIMIT + 1);
    localparam int RW = (READ_TIMEOUT > 2) ? $clog2(READ_TIMEOUT) : 1;
    localparam logic [1:0] ID_SCR = 2'd0, ID_SPR = 2'd1, ID_CPU = 2'd2, ID_CMD = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cpu_age_q, cpu_age_d;
    logic [RW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [16:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [3:0][31:0] rdata_q, rdata_d;
    logic [3:0]       rdata_en_q, rdata_en_d;
    logic             terr_q, terr_d;

    logic       grant, win_write, cpu_aged, rd_done, rd_abort;
    logic [1:0] win;

    assign cpu_aged = (cpu_age_q == AW'(CPU_AGE_LIMIT));
    assign rd_done  = (state_q == ST_READ) && vram_rdata_en;
    assign rd_abort = (state_q == ST_READ) && !vram_rdata_en && (rd_cnt_q == RW'(READ_TIMEOUT - 1));

    always_comb begin
        grant      = 1'b0;
        win        = ID_SCR;
        win_write  = 1'b0;
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_cnt_d   = rd_cnt_q;
        rdata_d    = rdata_q;
        rdata_en_d = 4'b0000;
        terr_d     = terr_q;

        if (state_q == ST_IDLE && !initial_busy) begin
            if (scr_valid) begin
                grant = 1'b1; win = ID_SCR;
            end else if (cpu_valid && cpu_aged) begin
                grant = 1'b1; win = ID_CPU;
            end else if (spr_valid) begin
                grant = 1'b1; win = ID_SPR;
            end else if (cpu_valid) begin
                grant = 1'b1; win = ID_CPU;
            end else if (cmd_valid) begin
                grant = 1'b1; win = ID_CMD;
            end
        end

        case (win)
            ID_SCR:  begin addr_d = grant ? scr_address : addr_q; end
            ID_SPR:  begin addr_d = grant ? spr_address : addr_q; end
            ID_CPU:  begin win_write = cpu_write; addr_d = grant ? cpu_address : addr_q; end
            default: begin win_write = cmd_write; addr_d = grant ? cmd_address : addr_q; end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d  = win;
                    rd_cnt_d = '0;
                    state_d  = win_write ? ST_WRITE : ST_READ;
                    wdata_d  = (win == ID_CPU) ? cpu_wdata : ((win == ID_CMD) ? cmd_wdata : 8'h00);
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                rd_cnt_d = rd_cnt_q + RW'(1);
                if (rd_done) begin
                    rdata_d[owner_q]    = vram_rdata;
                    rdata_en_d[owner_q] = 1'b1;
                    state_d             = ST_IDLE;
                end else if (rd_abort) begin
                    rdata_d[owner_q]    = 32'h0;
                    rdata_en_d[owner_q] = 1'b1;
                    terr_d              = 1'b1;
                    state_d             = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Age only counts real waiting; a granted or withdrawn CPU starts over.
        if (!cpu_valid || (grant && win == ID_CPU)) begin
            cpu_age_d = '0;
        end else if (!cpu_aged) begin
            cpu_age_d = cpu_age_q + AW'(1);
        end else begin
            cpu_age_d = cpu_age_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cpu_age_q  <= '0;
            rd_cnt_q   <= '0;
            owner_q    <= ID_SCR;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rdata_en_q <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_age_q  <= cpu_age_d;
            rd_cnt_q   <= rd_cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rdata_en_q <= rdata_en_d;
            terr_q     <= terr_d;
        end
    end

    assign scr_ready     = grant && (win == ID_SCR);
    assign spr_ready     = grant && (win == ID_SPR);
    assign cpu_ready     = grant && (win == ID_CPU);
    assign cmd_ready     = grant && (win == ID_CMD);
    assign scr_rdata     = rdata_q[ID_SCR];
    assign spr_rdata     = rdata_q[ID_SPR];
    assign cpu_rdata     = rdata_q[ID_CPU];
    assign cmd_rdata     = rdata_q[ID_CMD];
    assign scr_rdata_en  = rdata_en_q[ID_SCR];
    assign spr_rdata_en  = rdata_en_q[ID_SPR];
    assign cpu_rdata_en  = rdata_en_q[ID_CPU];
    assign cmd_rdata_en  = rdata_en_q[ID_CMD];
    assign vram_address  = addr_q;
    assign vram_wdata    = wdata_q;
    assign vram_valid    = (state_q != ST_IDLE);
    assign vram_write    = (state_q == ST_WRITE);
    assign timeout_error = terr_q;
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb/tb_vdp_vram_arbiter.sv - scoreboard bench for vdp_vram_arbiter
module tb_vdp_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        initial_busy = 1'b1;
    logic [16:0] scr_address = '0, spr_address = '0, cpu_address = '0, cmd_address = '0;
    logic        scr_valid = 1'b0, spr_valid = 1'b0, cpu_valid = 1'b0, cmd_valid = 1'b0;
    logic        cpu_write = 1'b0, cmd_write = 1'b0;
    logic [7:0]  cpu_wdata = '0, cmd_wdata = '0;
    logic        scr_ready, spr_ready, cpu_ready, cmd_ready;
    logic [31:0] scr_rdata, spr_rdata, cpu_rdata, cmd_rdata;
    logic        scr_rdata_en, spr_rdata_en, cpu_rdata_en, cmd_rdata_en;
    logic [16:0] vram_address;
    logic        vram_write, vram_valid;
    logic [7:0]  vram_wdata;
    logic [31:0] vram_rdata = '0;
    logic        vram_rdata_en = 1'b0;
    logic        timeout_error;

    vdp_vram_arbiter dut (
        .clk(clk), .reset_n(reset_n), .initial_busy(initial_busy),
        .scr_address(scr_address), .spr_address(spr_address),
        .cpu_address(cpu_address), .cmd_address(cmd_address),
        .scr_valid(scr_valid), .spr_valid(spr_valid), .cpu_valid(cpu_valid), .cmd_valid(cmd_valid),
        .cpu_write(cpu_write), .cmd_write(cmd_write), .cpu_wdata(cpu_wdata), .cmd_wdata(cmd_wdata),
        .scr_ready(scr_ready), .spr_ready(spr_ready), .cpu_ready(cpu_ready), .cmd_ready(cmd_ready),
        .scr_rdata(scr_rdata), .spr_rdata(spr_rdata), .cpu_rdata(cpu_rdata), .cmd_rdata(cmd_rdata),
        .scr_rdata_en(scr_rdata_en), .spr_rdata_en(spr_rdata_en),
        .cpu_rdata_en(cpu_rdata_en), .cmd_rdata_en(cmd_rdata_en),
        .vram_address(vram_address), .vram_write(vram_write), .vram_valid(vram_valid),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_rdata_en(vram_rdata_en),
        .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [16:0] a; logic w; logic [7:0] d; } txn_t;
    typedef struct { int id; logic [31:0] d; } rd_t;

    int   exp_grant[$];
    txn_t exp_txn[$];
    rd_t  exp_rd[$];
    int   checks = 0, errors = 0;
    logic [31:0] mem [int];
    logic mem_silent = 1'b0;
    logic spr_sticky = 1'b0;
    int   busy_vv = 0, busy_rdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int idx);
        return mem.exists(idx) ? mem[idx] : 32'h0;
    endfunction

    function automatic int first_id(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] rdata_of(input int id);
        case (id)
            0: return scr_rdata;
            1: return spr_rdata;
            2: return cpu_rdata;
            default: return cmd_rdata;
        endcase
    endfunction

    // Memory model: 3-cycle read latency, writes merge one byte lane.
    initial begin
        int lat;
        logic [31:0] w;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            vram_rdata_en = 1'b0;
            if (vram_valid && vram_write) begin
                w = mem_rd(int'(vram_address[16:2]));
                w[8*vram_address[1:0] +: 8] = vram_wdata;
                mem[int'(vram_address[16:2])] = w;
                lat = 0;
            end else if (vram_valid) begin
                lat++;
                if (lat == 3 && !mem_silent) begin
                    vram_rdata_en = 1'b1;
                    vram_rdata    = mem_rd(int'(vram_address[16:2]));
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Requester driver: a granted request is withdrawn after the grant edge.
    initial begin
        logic [3:0] g;
        forever begin
            @(negedge clk);
            g = {cmd_ready, cpu_ready, spr_ready, scr_ready};
            @(posedge clk); #1;
            if (g[0]) scr_valid = 1'b0;
            if (g[1] && !spr_sticky) spr_valid = 1'b0;
            if (g[2]) cpu_valid = 1'b0;
            if (g[3]) cmd_valid = 1'b0;
        end
    end

    // Monitor
    logic prev_valid = 1'b0, prev_write = 1'b0;
    always @(negedge clk) begin
        logic [3:0] rdy, rv;
        txn_t t;
        rd_t  r;
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_write = 1'b0;
        end else begin
            rdy = {cmd_ready, cpu_ready, spr_ready, scr_ready};
            if (initial_busy && vram_valid && !prev_valid) busy_vv++;
            if (rdy != 4'b0) begin
                if ($countones(rdy) != 1) chk("one_ready", rdy, 4'b0001 << first_id(rdy));
                if (initial_busy) begin
                    busy_rdy++;
                    chk("ready_while_busy", rdy, 4'b0);
                end else if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", rdy, 4'b0);
                end else begin
                    chk("grant_id", first_id(rdy), exp_grant.pop_front());
                end
            end
            if (prev_valid && prev_write) chk("write_one_cycle", vram_valid, 1'b0);
            if (vram_valid && !prev_valid) begin
                if (exp_txn.size() == 0) begin
                    chk("unexpected_txn", vram_address, 17'h0);
                end else begin
                    t = exp_txn.pop_front();
                    chk("txn_addr", vram_address, t.a);
                    chk("txn_write", vram_write, t.w);
                    if (t.w) chk("txn_wdata", vram_wdata, t.d);
                end
            end
            rv = {cmd_rdata_en, cpu_rdata_en, spr_rdata_en, scr_rdata_en};
            if (rv != 4'b0) begin
                if (exp_rd.size() == 0 || $countones(rv) != 1) begin
                    chk("unexpected_rdata_en", rv, 4'b0);
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_id", first_id(rv), r.id);
                    chk("rd_data", rdata_of(r.id), r.d);
                end
            end
            prev_valid = vram_valid;
            prev_write = vram_write;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500; i++) begin
            if (exp_grant.size() == 0 && exp_txn.size() == 0 && exp_rd.size() == 0 && !vram_valid) break;
            step(1);
        end
        step(2);
        chk({name, "_grants_left"}, exp_grant.size(), 0);
        chk({name, "_txns_left"}, exp_txn.size(), 0);
        chk({name, "_reads_left"}, exp_rd.size(), 0);
    endtask

    initial begin
        logic [31:0] w;
        int t, found;
        mem[32'h40] = 32'hAAAA_0001;
        mem[32'h80] = 32'h1234_5678;
        mem[32'h81] = 32'h0BAD_F00D;
        mem[32'hC0] = 32'hCCCC_0003;

        // Reset state
        step(3);
        chk("rst_vram_valid", vram_valid, 1'b0);
        chk("rst_vram_write", vram_write, 1'b0);
        chk("rst_vram_address", vram_address, 17'h0);
        chk("rst_vram_wdata", vram_wdata, 8'h0);
        chk("rst_rdata_en", {scr_rdata_en, spr_rdata_en, cpu_rdata_en, cmd_rdata_en}, 4'b0);
        chk("rst_scr_rdata", scr_rdata, 32'h0);
        chk("rst_timeout_error", timeout_error, 1'b0);
        reset_n = 1'b1;

        // Initial busy with all four requesting; CPU is fully aged on release
        scr_address = 17'h00100;
        spr_address = 17'h00200;
        cpu_address = 17'h10003; cpu_write = 1'b1; cpu_wdata = 8'hA5;
        cmd_address = 17'h00300; cmd_write = 1'b0; cmd_wdata = 8'h00;
        scr_valid = 1'b1; spr_valid = 1'b1; cpu_valid = 1'b1; cmd_valid = 1'b1;
        step(1000);
        chk("busy_no_vram_valid", busy_vv, 0);
        chk("busy_no_ready", busy_rdy, 0);
        exp_grant = '{0, 2, 1, 3};
        exp_txn.push_back('{17'h00100, 1'b0, 8'h00});
        exp_txn.push_back('{17'h10003, 1'b1, 8'hA5});
        exp_txn.push_back('{17'h00200, 1'b0, 8'h00});
        exp_txn.push_back('{17'h00300, 1'b0, 8'h00});
        exp_rd.push_back('{0, 32'hAAAA_0001});
        exp_rd.push_back('{1, 32'h1234_5678});
        exp_rd.push_back('{3, 32'hCCCC_0003});
        initial_busy = 1'b0;
        drain("release");
        w = mem_rd(32'h4000);
        chk("mem_write_lane3", w[31:24], 8'hA5);
        chk("mem_write_lane0", w[7:0], 8'h00);

        // CPU aging against a continuous sprite stream
        cpu_address = 17'h00204; cpu_write = 1'b0;
        exp_grant = '{1, 1, 1, 1, 2, 1};
        for (int i = 0; i < 4; i++) begin
            exp_txn.push_back('{17'h00200, 1'b0, 8'h00});
            exp_rd.push_back('{1, 32'h1234_5678});
        end
        exp_txn.push_back('{17'h00204, 1'b0, 8'h00});
        exp_rd.push_back('{2, 32'h0BAD_F00D});
        exp_txn.push_back('{17'h00200, 1'b0, 8'h00});
        exp_rd.push_back('{1, 32'h1234_5678});
        spr_sticky = 1'b1;
        spr_valid = 1'b1; cpu_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_ready) begin found = 1; break; end
        end
        chk("cpu_aged_grant_seen", found, 1);
        spr_sticky = 1'b0;
        drain("aging");

        // Read timeout on a command read
        mem_silent = 1'b1;
        exp_grant.push_back(3);
        exp_txn.push_back('{17'h00300, 1'b0, 8'h00});
        exp_rd.push_back('{3, 32'h0});
        cmd_valid = 1'b1;
        t = 0; found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (vram_valid) t++;
            if (cmd_rdata_en) begin found = 1; break; end
        end
        chk("timeout_seen", found, 1);
        chk("timeout_cycles", t, 64);
        chk("timeout_cmd_rdata", cmd_rdata, 32'h0);
        chk("timeout_error_set", timeout_error, 1'b1);
        mem_silent = 1'b0;
        step(1);
        exp_grant.push_back(0);
        exp_txn.push_back('{17'h00100, 1'b0, 8'h00});
        exp_rd.push_back('{0, 32'hAAAA_0001});
        scr_valid = 1'b1;
        drain("after_timeout");
        chk("timeout_error_sticky", timeout_error, 1'b1);

        // Reset in the middle of a read
        mem_silent = 1'b1;
        exp_grant.push_back(2);
        exp_txn.push_back('{17'h00204, 1'b0, 8'h00});
        cpu_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (vram_valid) break;
            step(1);
        end
        step(5);
        chk("pre_reset_in_read", vram_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_vram_valid", vram_valid, 1'b0);
        chk("rst_mid_vram_address", vram_address, 17'h0);
        chk("rst_mid_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mid_spr_rdata", spr_rdata, 32'h0);
        chk("rst_mid_timeout_error", timeout_error, 1'b0);
        step(3);
        mem_silent = 1'b0;
        reset_n = 1'b1;
        step(100);
        chk("post_reset_grants_left", exp_grant.size(), 0);
        chk("post_reset_txns_left", exp_txn.size(), 0);
        chk("post_reset_idle", vram_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vdp_vram_arbiter.md
# vdp_vram_arbiter

Shares the single VDP VRAM port (`vram_*`: 17-bit byte address, 8-bit write data, 32-bit word read data) among four requesters: screen fetch, sprite fetch, CPU port access and command engine. It sits between those VDP sub-blocks and the external VRAM controller. It applies fixed priority with CPU aging, keeps at most one transaction in flight, and blocks all VRAM traffic while `initial_busy` is high. It also recovers from a VRAM controller that never answers a read.

## Interface
- `CPU_AGE_LIMIT`, default 16: wait cycles after which a pending CPU request outranks sprite and command.
- `READ_TIMEOUT`, default 64: cycles in ST_READ before the read is aborted.
- `clk`  in  1  system clock (42.95454 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `initial_busy`  in  1  1 = VRAM not yet usable; no grants issued
- `scr_address` / `spr_address` / `cpu_address` / `cmd_address`  in  17 each  request byte address
- `scr_valid` / `spr_valid` / `cpu_valid` / `cmd_valid`  in  1 each  request pending; held with stable fields until ready
- `cpu_write` / `cmd_write`  in  1 each  1 = write, 0 = read (screen and sprite are read-only)
- `cpu_wdata` / `cmd_wdata`  in  8 each  write byte
- `scr_ready` / `spr_ready` / `cpu_ready` / `cmd_ready`  out  1 each  one-cycle grant pulse (combinational)
- `scr_rdata` / `spr_rdata` / `cpu_rdata` / `cmd_rdata`  out  32 each  read word, held until that requester's next read completes
- `scr_rdata_en` / `spr_rdata_en` / `cpu_rdata_en` / `cmd_rdata_en`  out  1 each  one-cycle read-data strobe
- `vram_address`  out  17  to VRAM controller
- `vram_write`  out  1  1 = write
- `vram_valid`  out  1  transaction active
- `vram_wdata`  out  8  write byte
- `vram_rdata`  in  32  word at `vram_address[16:2]`
- `vram_rdata_en`  in  1  read data valid
- `timeout_error`  out  1  sticky; set on read abort, cleared only by reset

## Operation
- States:
  - ST_IDLE: may grant.
  - ST_WRITE: `vram_valid=1`, `vram_write=1` for exactly one cycle, then ST_IDLE.
  - ST_READ: `vram_valid=1`, `vram_write=0`, held until `vram_rdata_en` is sampled 1 or the timeout fires, then ST_IDLE.
- Grant occurs only in ST_IDLE with `initial_busy=0`.
  - The winner's `*_ready` is 1 that cycle, and address, write and wdata are registered.
  - Next state is ST_WRITE or ST_READ.
  - Owner ID (2 bits) is latched for read-data routing.
- Priority, highest first: screen > sprite > CPU > command.
  - When `cpu_age == CPU_AGE_LIMIT`: screen > CPU > sprite > command.
- `cpu_age`: +1 per cycle while `cpu_valid=1` and the CPU is not granted; saturates at `CPU_AGE_LIMIT`; cleared to 0 on CPU grant or when `cpu_valid=0`.
- Read completion: when `vram_rdata_en=1` in ST_READ, `vram_rdata` is copied into the owner's `*_rdata`. The owner's `*_rdata_en` pulses 1 on the next cycle. Other requesters' rdata is untouched.
- Read timeout: `rd_cnt` counts cycles in ST_READ. At `rd_cnt == READ_TIMEOUT-1` without `vram_rdata_en`:
  - the owner receives `*_rdata=0` with an `*_rdata_en` pulse;
  - `timeout_error` is set to 1;
  - state returns to ST_IDLE.
- `initial_busy`:
  - Rising mid-transaction: the current transaction completes normally; no further grants are issued.
  - While high: `vram_valid` stays 0 and requests simply wait (no ready).
- Address is passed unmodified; word alignment of reads is the VRAM controller's job.

## Timing
- Reset values: `vram_valid=0`, `vram_write=0`, `vram_address=0`, `vram_wdata=0`, all `*_rdata=0`, all `*_rdata_en=0`, `timeout_error=0`. State is ST_IDLE, `cpu_age=0`, `rd_cnt=0`.
- Reset mid-transaction aborts it immediately; no `*_rdata_en` is produced for the aborted read.
- Grant at cycle N (ready=1). `vram_valid` rises at N+1 (registered). The requester drops or changes its valid at N+1.
- Write: valid high at N+1 only, back in ST_IDLE at N+2. Back-to-back writes therefore achieve 1 per 2 cycles.
- Read: `vram_rdata_en` sampled high at cycle M → `vram_valid=0` at M+1, `*_rdata_en=1` and data valid at M+1, next grant possible at M+1.
- Simultaneous requests: exactly one ready per cycle; losers keep valid asserted and receive no ready.
- `vram_rdata_en` outside ST_READ is ignored.
- `*_ready` is never asserted outside ST_IDLE or while `initial_busy=1`.

## Test plan
- **Initial busy:** `initial_busy=1` for 1000 cycles with all four valids high → `vram_valid` stays 0 and no ready is asserted. Drop `initial_busy` → `scr_ready` pulses first.
- **CPU write:** `cpu_write=1`, `cpu_address=17'h1_0003`, `cpu_wdata=8'hA5` → `vram_valid`/`vram_write` high for exactly 1 cycle with that address and data. VRAM model word `0x4000` bits `[31:24]` = `0xA5`.
- **Read routing:** a memory model with 3-cycle latency holds `0x12345678`; a `spr` read is issued → `spr_rdata_en` pulses once with `0x12345678`, and `scr`/`cpu`/`cmd` `rdata_en` stay 0.
- **CPU aging:** sprite valid continuously plus CPU valid; `CPU_AGE_LIMIT=16` → CPU is granted no later than the first ST_IDLE after its wait counter reaches 16, before the next sprite grant. Screen requests still win over the CPU.
- **Read timeout:** the memory model never asserts `vram_rdata_en` on a `cmd` read → after 64 cycles `cmd_rdata_en=1` with `cmd_rdata=0`, `timeout_error=1`, and the next request is granted.
- **Reset mid-read:** `reset_n=0` during ST_READ → all outputs return to reset values asynchronously, and no `*_rdata_en` follows after release.
